poly_fun_pipe: RTL and testbench

Pipelined evaluator of a fixed-coefficient quadratic polynomial, y = W2·x² + W1·x + W0, on signed WIDTH-bit samples. Accepts one new sample every clock with no handshake and produces one result per clock after a fixed three-stage pipeline latency. Used as a basic streaming arithmetic block in front of downstream datapath logic. It also serves as the reference example for registered multi-stage arithmetic.

---
 rtl/poly_fun_pipe.sv | 38 +++
 tb/tb_poly_fun_pipe.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/poly_fun_pipe.sv
// Three-stage pipelined evaluator of y = W2*x^2 + W1*x + W0 on signed WIDTH-bit samples.
// All arithmetic wraps modulo 2^WIDTH; one sample in and one result out every clock.
module poly_fun_pipe #(
    parameter int WIDTH = 16,
    parameter int W2    = 1,
    parameter int W1    = 1,
    parameter int W0    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x,
    output logic signed [WIDTH-1:0] y
);

    localparam logic signed [WIDTH-1:0] C2 = WIDTH'(W2);
    localparam logic signed [WIDTH-1:0] C1 = WIDTH'(W1);
    localparam logic signed [WIDTH-1:0] C0 = WIDTH'(W0);

    logic signed [WIDTH-1:0] x_r;
    logic signed [WIDTH-1:0] x_sq;
    logic signed [WIDTH-1:0] w1_x;

    // Truncating each product/sum to WIDTH bits leaves the final result unchanged mod 2^WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r  <= '0;
            x_sq <= '0;
            w1_x <= '0;
            y    <= '0;
        end else begin
            x_r  <= x;
            x_sq <= x_r * x_r;
            w1_x <= C1 * x_r;
            y    <= C2 * x_sq + w1_x + C0;
        end
    end

endmodule

// File: tb/tb_poly_fun_pipe.sv
// Self-checking bench for poly_fun_pipe (WIDTH=16, W2=3, W1=2, W0=4).
// Expected y comes from the polynomial applied to the sample history, with reset edges tracked.
module tb_poly_fun_pipe;

    logic               clk;
    logic               rst;
    logic signed [15:0] x;
    logic signed [15:0] y;

    int tests_run    = 0;
    int tests_failed = 0;

    int hist[$];
    bit rsth[$];

    poly_fun_pipe #(.WIDTH(16), .W2(3), .W1(2), .W0(4)) dut (
        .clk(clk),
        .rst(rst),
        .x  (x),
        .y  (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] poly(input int xv);
        longint v;
        logic [15:0] t;
        v = 3 * longint'(xv) * longint'(xv) + 2 * longint'(xv) + 4;
        t = v[15:0];
        return signed'(t);
    endfunction

    // y after edge k: 0 on a reset edge, W0 if edge k-1 was a reset, else P(sample from edge k-2).
    function automatic logic signed [15:0] model_y();
        int k;
        k = hist.size() - 1;
        if (rsth[k]) return 16'sd0;
        if (k < 1 || rsth[k-1]) return 16'sd4;
        if (k < 2) return poly(0);
        return poly(hist[k-2]);
    endfunction

    // Drive one edge; x becomes X just after the edge when glitch is set.
    task automatic step(input logic r, input logic signed [15:0] xv, input bit glitch,
                        output logic signed [15:0] e);
        @(negedge clk);
        rst = r;
        x   = xv;
        @(posedge clk);
        hist.push_back(r ? 0 : int'(xv));
        rsth.push_back(r);
        #1;
        e = model_y();
        if (glitch) x = 'x;
    endtask

    task automatic test_reset();
        logic signed [15:0] e;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'(-1), 1'b0, e);
            tests_run++;
            if (y !== 16'sd0) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: y=%0d expected=0", i, y);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'($urandom), 1'b0, e);
            tests_run++;
            if (y !== 16'sd4) begin
                tests_failed++;
                $display("FAIL reset_release[%0d]: y=%0d expected=4", i, y);
            end
        end
    endtask

    task automatic test_stream();
        logic signed [15:0] e;
        logic signed [15:0] xs [7];
        logic signed [15:0] ys [5];
        xs = '{16'sd5, -16'sd3, 16'sd10, 16'sd100, 16'sd0, 16'sd0, 16'sd0};
        ys = '{16'sd89, 16'sd25, 16'sd324, 16'sd30204, 16'sd4};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, xs[i], 1'b0, e);
            tests_run++;
            if (y !== e) begin
                tests_failed++;
                $display("FAIL stream_model[%0d]: y=%0d expected=%0d", i, y, e);
            end
            if (i >= 2) begin
                tests_run++;
                if (y !== ys[i-2]) begin
                    tests_failed++;
                    $display("FAIL stream_const[%0d]: y=%0d expected=%0d", i, y, ys[i-2]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic signed [15:0] e;
        step(1'b0, 16'sd255, 1'b0, e);
        step(1'b0, 16'sd0, 1'b0, e);
        step(1'b0, 16'sd0, 1'b0, e);
        tests_run++;
        if (y !== -16'sd1019) begin
            tests_failed++;
            $display("FAIL wrap_255: y=%0d expected=-1019", y);
        end
    endtask

    task automatic test_xglitch();
        logic signed [15:0] e;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 16'($urandom), 1'b1, e);
            tests_run++;
            if (y !== e) begin
                tests_failed++;
                $display("FAIL xglitch[%0d]: y=%0d expected=%0d", i, y, e);
            end
        end
    endtask

    task automatic test_flush();
        logic signed [15:0] e;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'($urandom), 1'b0, e);
            tests_run++;
            if (y !== e) begin
                tests_failed++;
                $display("FAIL flush_stream[%0d]: y=%0d expected=%0d", i, y, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'sd0, 1'b0, e);
            tests_run++;
            if (y !== e) begin
                tests_failed++;
                $display("FAIL flush_drain[%0d]: y=%0d expected=%0d", i, y, e);
            end
        end
        tests_run++;
        if (y !== 16'sd4) begin
            tests_failed++;
            $display("FAIL flush_final: y=%0d expected=4", y);
        end
    endtask

    task automatic test_midreset();
        logic signed [15:0] e;
        for (int i = 0; i < 4; i++) step(1'b0, 16'($urandom), 1'b0, e);
        step(1'b1, 16'($urandom), 1'b0, e);
        tests_run++;
        if (y !== 16'sd0) begin
            tests_failed++;
            $display("FAIL midreset_zero: y=%0d expected=0", y);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'($urandom), 1'b0, e);
            tests_run++;
            if (y !== e) begin
                tests_failed++;
                $display("FAIL midreset_resume[%0d]: y=%0d expected=%0d", i, y, e);
            end
        end
    endtask

    task automatic test_random();
        logic signed [15:0] e;
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) == 0), 16'($urandom), $urandom_range(0, 1) == 1, e);
            tests_run++;
            if (y !== e) begin
                tests_failed++;
                $display("FAIL random[%0d]: y=%0d expected=%0d", i, y, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        x   = '0;
        test_reset();
        test_stream();
        test_wrap();
        test_xglitch();
        test_flush();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
